// File: rtl/map_block_writer.sv
// Map-cell encoder: turns placement commands into map RAM writes, tracks one start/goal cell, sweeps clear.
// Optional `MAP_BLOCK_WRITER_STATS_EN adds wall_cnt backed by a shadow wall bitmap.
module map_block_writer #(
  parameter int         ADDR_W    = 8,
  parameter int         MAP_SIZE  = 256,
  parameter logic [7:0] FREE_CODE = 8'h01
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              clear_req,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [6:0]        cmd_arg,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic [ADDR_W-1:0] start_pos,
  output logic [ADDR_W-1:0] goal_pos,
  output logic              start_vld,
  output logic              goal_vld
`ifdef MAP_BLOCK_WRITER_STATS_EN
  ,
  output logic [ADDR_W:0]   wall_cnt
`endif
);

  localparam logic [1:0] CMD_FREE  = 2'd0;
  localparam logic [1:0] CMD_WALL  = 2'd1;
  localparam logic [1:0] CMD_START = 2'd2;
  localparam logic [1:0] CMD_GOAL  = 2'd3;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAP_SIZE - 1);

  // Bytes with bit7=0 and bits[6:5]=2'b10 belong to the search marks.
  if (!FREE_CODE[7] && (FREE_CODE[6:5] == 2'b10)) begin : g_bad_free_code
    $error("FREE_CODE lies in the reserved search-mark space");
  end
  if (MAP_SIZE > (1 << ADDR_W)) begin : g_bad_map_size
    $error("MAP_SIZE exceeds the address space");
  end

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_WRITE, S_CLEAR} state_e;

  typedef struct packed {
    logic [1:0]        ctype;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        arg;
  } cmd_t;

  state_e            state, state_d;
  cmd_t              cmd_q;
  logic [ADDR_W:0]   cnt, cnt_d, cnt_nxt;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              cmd_acc, need_erase, clear_last, start_hit, goal_hit;
  logic [ADDR_W-1:0] erase_addr;

  function automatic logic [7:0] encode(input logic [1:0] t, input logic [6:0] arg);
    case (t)
      CMD_START: encode = 8'h7F;
      CMD_GOAL:  encode = 8'h00;
      CMD_WALL:  encode = {1'b1, arg};
      default:   encode = FREE_CODE;
    endcase
  endfunction

  assign cmd_ready  = (state == S_IDLE) && !clear_req && !p_reset;
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign busy       = (state != S_IDLE);
  assign clear_last = (cnt == LAST_IDX);
  assign cnt_nxt    = cnt + 1'b1;

  // Moving an existing start/goal to a new cell frees the old cell first.
  assign need_erase = ((cmd_type == CMD_START) && start_vld && (start_pos != cmd_addr)) ||
                      ((cmd_type == CMD_GOAL)  && goal_vld  && (goal_pos  != cmd_addr));
  assign erase_addr = (cmd_type == CMD_START) ? start_pos : goal_pos;

  assign start_hit  = start_vld && (start_pos == cmd_q.addr);
  assign goal_hit   = goal_vld  && (goal_pos  == cmd_q.addr);

  always_ff @(posedge m_clock) begin
    if (p_reset) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (clear_req)    state_d = S_CLEAR;
        else if (cmd_acc) state_d = need_erase ? S_ERASE : S_WRITE;
      end
      S_ERASE: state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_CLEAR: if (clear_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write port is registered, so this computes what the next cycle drives.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    cnt_d     = cnt;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = FREE_CODE;
          cnt_d     = '0;
        end else if (cmd_acc) begin
          wr_en_d = 1'b1;
          if (need_erase) begin
            wr_addr_d = erase_addr;
            wr_data_d = FREE_CODE;
          end else begin
            wr_addr_d = cmd_addr;
            wr_data_d = encode(cmd_type, cmd_arg);
          end
        end
      end
      S_ERASE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cmd_q.addr;
        wr_data_d = encode(cmd_q.ctype, cmd_q.arg);
      end
      S_CLEAR: begin
        if (!clear_last) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_nxt[ADDR_W-1:0];
          wr_data_d = FREE_CODE;
          cnt_d     = cnt_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cnt     <= '0;
      cmd_q   <= '0;
    end else begin
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      cnt     <= cnt_d;
      if (cmd_acc) cmd_q <= '{ctype: cmd_type, addr: cmd_addr, arg: cmd_arg};
    end
  end

  // Overwriting a tracked cell with anything else drops its valid flag.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      start_pos <= '0;
      goal_pos  <= '0;
      start_vld <= 1'b0;
      goal_vld  <= 1'b0;
    end else if ((state == S_CLEAR) && clear_last) begin
      start_vld <= 1'b0;
      goal_vld  <= 1'b0;
    end else if (state == S_WRITE) begin
      if (cmd_q.ctype == CMD_START) begin
        start_pos <= cmd_q.addr;
        start_vld <= 1'b1;
      end else if (start_hit) begin
        start_vld <= 1'b0;
      end
      if (cmd_q.ctype == CMD_GOAL) begin
        goal_pos <= cmd_q.addr;
        goal_vld <= 1'b1;
      end else if (goal_hit) begin
        goal_vld <= 1'b0;
      end
    end
  end

`ifdef MAP_BLOCK_WRITER_STATS_EN
  localparam logic [ADDR_W:0] WALL_MAX = (ADDR_W+1)'(MAP_SIZE);

  logic [MAP_SIZE-1:0] wall_map;

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      wall_cnt <= '0;
      wall_map <= '0;
    end else if ((state == S_CLEAR) && clear_last) begin
      wall_cnt <= '0;
      wall_map <= '0;
    end else if (state == S_WRITE) begin
      if (cmd_q.ctype == CMD_WALL) begin
        wall_map[cmd_q.addr] <= 1'b1;
        if (wall_cnt != WALL_MAX) wall_cnt <= wall_cnt + 1'b1;
      end else if (wall_map[cmd_q.addr]) begin
        wall_map[cmd_q.addr] <= 1'b0;
        if (wall_cnt != '0) wall_cnt <= wall_cnt - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_map_block_writer.sv
// Bench for map_block_writer: directed table, random commands against a rule-level model, reset/clear corners.
module tb_map_block_writer;

  localparam logic [1:0] T_FREE = 2'd0, T_WALL = 2'd1, T_START = 2'd2, T_GOAL = 2'd3;
  localparam logic [7:0] FREE = 8'h01;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = '0;
  logic [7:0] cmd_addr = '0;
  logic [6:0] cmd_arg = '0;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
  logic       busy;
  logic [7:0] start_pos, goal_pos;
  logic       start_vld, goal_vld;
`ifdef MAP_BLOCK_WRITER_STATS_EN
  logic [8:0] wall_cnt;
`endif

  map_block_writer #(.ADDR_W(8), .MAP_SIZE(256), .FREE_CODE(8'h01)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .clear_req(clear_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_arg(cmd_arg), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .start_pos(start_pos), .goal_pos(goal_pos),
    .start_vld(start_vld), .goal_vld(goal_vld)
`ifdef MAP_BLOCK_WRITER_STATS_EN
    , .wall_cnt(wall_cnt)
`endif
  );

  always #5 m_clock = ~m_clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: tracking, wall bookkeeping and the expected RAM image.
  logic [7:0] m_sp = '0, m_gp = '0;
  logic       m_sv = 1'b0, m_gv = 1'b0;
  int         m_wc = 0;
  bit         m_wall [256];
  logic [7:0] m_mem [256];
  logic [7:0] obs_mem [256];

  always @(negedge m_clock) if (wr_en === 1'b1) obs_mem[wr_addr] = wr_data;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] enc_ref(input logic [1:0] t, input logic [6:0] g);
    case (t)
      T_START: return 8'h7F;
      T_GOAL:  return 8'h00;
      T_WALL:  return {1'b1, g};
      default: return FREE;
    endcase
  endfunction

  task automatic model_cmd(input logic [1:0] t, input logic [7:0] a, input logic [6:0] g,
                           output int nw, output logic [15:0] w0, output logic [15:0] w1);
    logic [15:0] w [2];
    nw = 0; w[0] = '0; w[1] = '0;
    if (t == T_START && m_sv && m_sp != a) begin w[nw] = {m_sp, FREE}; nw++; end
    if (t == T_GOAL  && m_gv && m_gp != a) begin w[nw] = {m_gp, FREE}; nw++; end
    w[nw] = {a, enc_ref(t, g)}; nw++;
    for (int i = 0; i < nw; i++) m_mem[w[i][15:8]] = w[i][7:0];
    case (t)
      T_START: begin m_sp = a; m_sv = 1'b1; if (m_gv && m_gp == a) m_gv = 1'b0; end
      T_GOAL:  begin m_gp = a; m_gv = 1'b1; if (m_sv && m_sp == a) m_sv = 1'b0; end
      default: begin
        if (m_sv && m_sp == a) m_sv = 1'b0;
        if (m_gv && m_gp == a) m_gv = 1'b0;
      end
    endcase
    if (t == T_WALL) begin m_wall[a] = 1'b1; if (m_wc < 256) m_wc++; end
    else if (m_wall[a]) begin m_wall[a] = 1'b0; if (m_wc > 0) m_wc--; end
    w0 = w[0]; w1 = w[1];
  endtask

  // Issue one command and check the cycle-exact write/ready pattern that follows.
  task automatic do_cmd(input string nm, input logic [1:0] t, input logic [7:0] a, input logic [6:0] g,
                        input int enw, input logic [15:0] ew0, input logic [15:0] ew1);
    @(negedge m_clock);
    cmd_type = t; cmd_addr = a; cmd_arg = g; cmd_valid = 1'b1;
    chk({nm, ".ready_in"}, cmd_ready, 1);
    @(posedge m_clock);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge m_clock);
      chk({nm, ".wr_en"}, wr_en, (k <= enw));
      chk({nm, ".busy"}, busy, (k <= enw));
      chk({nm, ".ready"}, cmd_ready, (k > enw));
      if (k <= enw) chk({nm, ".wr"}, {wr_addr, wr_data}, (k == 1) ? ew0 : ew1);
    end
  endtask

  task automatic chk_track(input string nm, input logic [7:0] sp, input logic sv,
                           input logic [7:0] gp, input logic gv);
    chk({nm, ".start_pos"}, start_pos, sp);
    chk({nm, ".start_vld"}, start_vld, sv);
    chk({nm, ".goal_pos"}, goal_pos, gp);
    chk({nm, ".goal_vld"}, goal_vld, gv);
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  a;
    logic [6:0]  g;
    int          nw;
    logic [15:0] w0, w1;
    logic [7:0]  sp;
    logic        sv;
    logic [7:0]  gp;
    logic        gv;
    int          wc;
  } vec_t;

  vec_t vec [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nw, wcount, ram_bad;
    logic [15:0] w0, w1;
    logic [1:0] rt;
    logic [7:0] ra;
    logic [6:0] rg;

    vec[0] = '{t:T_START, a:8'h12, g:7'h00, nw:1, w0:16'h127F, w1:16'h0, sp:8'h12, sv:1, gp:8'h00, gv:0, wc:0};
    vec[1] = '{t:T_START, a:8'h34, g:7'h00, nw:2, w0:16'h1201, w1:16'h347F, sp:8'h34, sv:1, gp:8'h00, gv:0, wc:0};
    vec[2] = '{t:T_GOAL,  a:8'h34, g:7'h00, nw:1, w0:16'h3400, w1:16'h0, sp:8'h34, sv:0, gp:8'h34, gv:1, wc:0};
    vec[3] = '{t:T_WALL,  a:8'h05, g:7'h2A, nw:1, w0:16'h05AA, w1:16'h0, sp:8'h34, sv:0, gp:8'h34, gv:1, wc:1};
    vec[4] = '{t:T_FREE,  a:8'h05, g:7'h00, nw:1, w0:16'h0501, w1:16'h0, sp:8'h34, sv:0, gp:8'h34, gv:1, wc:0};
    vec[5] = '{t:T_GOAL,  a:8'h40, g:7'h00, nw:2, w0:16'h3401, w1:16'h4000, sp:8'h34, sv:0, gp:8'h40, gv:1, wc:0};
    vec[6] = '{t:T_START, a:8'h40, g:7'h00, nw:1, w0:16'h407F, w1:16'h0, sp:8'h40, sv:1, gp:8'h40, gv:0, wc:0};
    vec[7] = '{t:T_WALL,  a:8'h40, g:7'h7F, nw:1, w0:16'h40FF, w1:16'h0, sp:8'h40, sv:0, gp:8'h40, gv:0, wc:1};
    vec[8] = '{t:T_START, a:8'h12, g:7'h00, nw:1, w0:16'h127F, w1:16'h0, sp:8'h12, sv:1, gp:8'h40, gv:0, wc:1};

    for (int i = 0; i < 256; i++) begin obs_mem[i] = '0; m_mem[i] = '0; m_wall[i] = 1'b0; end

    // Reset values
    repeat (3) @(negedge m_clock);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.cmd_ready", cmd_ready, 0);
    chk_track("rst", 8'h00, 0, 8'h00, 0);
`ifdef MAP_BLOCK_WRITER_STATS_EN
    chk("rst.wall_cnt", wall_cnt, 0);
`endif
    p_reset = 1'b0;
    #1 chk("rst.ready_after", cmd_ready, 1);

    // Full clear sweep
    @(negedge m_clock);
    clear_req = 1'b1;
    @(posedge m_clock);
    #1 clear_req = 1'b0;
    for (int k = 0; k < 256; k++) begin
      @(negedge m_clock);
      chk("clr.wr_en", wr_en, 1);
      chk("clr.busy", busy, 1);
      chk("clr.wr", {wr_addr, wr_data}, {k[7:0], FREE});
    end
    @(negedge m_clock);
    chk("clr.end_wr_en", wr_en, 0);
    chk("clr.end_busy", busy, 0);
    chk("clr.end_ready", cmd_ready, 1);
    chk_track("clr.end", 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) m_mem[i] = FREE;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      model_cmd(vec[i].t, vec[i].a, vec[i].g, nw, w0, w1);
      do_cmd($sformatf("vec%0d", i), vec[i].t, vec[i].a, vec[i].g, vec[i].nw, vec[i].w0, vec[i].w1);
      chk_track($sformatf("vec%0d", i), vec[i].sp, vec[i].sv, vec[i].gp, vec[i].gv);
`ifdef MAP_BLOCK_WRITER_STATS_EN
      chk($sformatf("vec%0d.wall_cnt", i), wall_cnt, vec[i].wc);
`endif
    end

    // Random commands on a small address pool to force collisions
    for (int i = 0; i < 80; i++) begin
      rt = 2'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 9)) + ((i % 3 == 0) ? 8'hF6 : 8'h00);
      rg = 7'($urandom);
      model_cmd(rt, ra, rg, nw, w0, w1);
      do_cmd($sformatf("rnd%0d", i), rt, ra, rg, nw, w0, w1);
      chk_track($sformatf("rnd%0d", i), m_sp, m_sv, m_gp, m_gv);
`ifdef MAP_BLOCK_WRITER_STATS_EN
      chk($sformatf("rnd%0d.wall_cnt", i), wall_cnt, m_wc);
`endif
      repeat ($urandom_range(0, 2)) @(negedge m_clock);
    end

    ram_bad = 0;
    for (int i = 0; i < 256; i++) if (obs_mem[i] !== m_mem[i]) ram_bad++;
    chk("ram_image_bad_cells", ram_bad, 0);

    // Reset in the 10th clear cycle aborts the sweep and tracking
    model_cmd(T_START, 8'h20, 7'h0, nw, w0, w1);
    do_cmd("pre_abort", T_START, 8'h20, 7'h0, nw, w0, w1);
    chk("pre_abort.start_vld", start_vld, 1);
    @(negedge m_clock);
    clear_req = 1'b1;
    @(posedge m_clock);
    #1 clear_req = 1'b0;
    repeat (10) @(negedge m_clock);
    chk("abort.cycle10_addr", wr_addr, 8'h09);
    p_reset = 1'b1;
    @(negedge m_clock);
    chk("abort.wr_en", wr_en, 0);
    chk("abort.busy", busy, 0);
    chk("abort.ready_in_reset", cmd_ready, 0);
    chk_track("abort", 8'h00, 0, 8'h00, 0);
    p_reset = 1'b0;
    #1 chk("abort.ready_after", cmd_ready, 1);
    @(negedge m_clock);
    chk("abort.no_write", wr_en, 0);

    // clear_req beats cmd_valid in the same cycle
    clear_req = 1'b1; cmd_valid = 1'b1; cmd_type = T_START; cmd_addr = 8'h77;
    #1 chk("prio.cmd_ready", cmd_ready, 0);
    @(posedge m_clock);
    #1 begin clear_req = 1'b0; cmd_valid = 1'b0; end
    @(negedge m_clock);
    chk("prio.first_wr", {wr_en, wr_addr, wr_data}, {1'b1, 8'h00, FREE});
    wcount = 1;
    for (int k = 0; k < 300 && busy; k++) begin
      @(negedge m_clock);
      if (wr_en) wcount++;
    end
    chk("prio.busy_done", busy, 0);
    chk("prio.write_count", wcount, 256);
    chk("prio.start_vld", start_vld, 0);
`ifdef MAP_BLOCK_WRITER_STATS_EN
    chk("prio.wall_cnt", wall_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
